// File: rtl/shift_word_deserializer.sv
// shift_word_deserializer
//
// Serial-to-parallel receiver for an MSB-first framed bitstream. WIDTH
// qualified bits, the first one tagged with sof, are packed into one word
// and offered on a valid/ready output port. Framing errors (a new sof
// arriving mid-word) and overruns (a completed word with nowhere to go)
// are reported through sticky flags.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   din        in   serial data bit
//   din_en     in   bit qualifier; din/sof are ignored when low
//   sof        in   start of frame; din is the MSB of a new word
//   out_ready  in   consumer can take out_data this cycle
//   clr_err    in   synchronous clear of overrun and frame_err
//   out_data   out  last completed word, MSB = first received bit
//   out_valid  out  out_data holds a word not yet accepted
//   busy       out  a frame is partially received (FSM in SHIFT)
//   overrun    out  sticky: a completed word was dropped
//   frame_err  out  sticky: a partial word was aborted by sof
//
// Handshake: a word transfers on every rising edge where out_valid=1 and
// out_ready=1. out_valid, once set, stays high with out_data stable until
// that transfer; out_ready may change freely and never reaches an output
// combinationally.
//
// busy is the FSM state itself (1 = SHIFT, 0 = IDLE) and serves as the
// state observation point for the two-state receiver FSM.

module shift_word_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             sof,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    // Count value at which the next qualified bit completes the word.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             word_done;
    logic             abort;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] restart;

    assign shifted = {shreg[WIDTH-2:0], din};
    assign restart = {{(WIDTH-1){1'b0}}, din};

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        cnt_n     = cnt;
        word_done = 1'b0;
        abort     = 1'b0;

        unique case (state)
            IDLE: begin
                // Bits without sof are noise between frames and are dropped.
                if (din_en && sof) begin
                    shreg_n = restart;
                    cnt_n   = CW'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (din_en) begin
                    if (sof) begin
                        // Restart on the new MSB; the partial word is lost.
                        abort   = 1'b1;
                        shreg_n = restart;
                        cnt_n   = CW'(1);
                    end else if (cnt == CNT_LAST) begin
                        word_done = 1'b1;
                        shreg_n   = shifted;
                        cnt_n     = '0;
                        state_n   = IDLE;
                    end else begin
                        shreg_n = shifted;
                        cnt_n   = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output port and sticky error flags
    // ------------------------------------------------------------------
    logic set_ovr;

    // A completed word is lost only when the holding register is full and
    // the consumer is not draining it in the same cycle.
    assign set_ovr = word_done && out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (word_done && (!out_valid || out_ready)) begin
                out_data  <= shifted;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A set in the same cycle as clr_err wins, so no event is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= set_ovr | (overrun   & ~clr_err);
            frame_err <= abort   | (frame_err & ~clr_err);
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_word_deserializer.sv
// Testbench for shift_word_deserializer: directed frames followed by
// randomized traffic, checked against a bit-list reference model and a
// word scoreboard.

module tb_shift_word_deserializer;

  localparam int WIDTH = 4;

  // ---------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------
  logic clk;
  logic rst;
  logic din, din_en, sof, out_ready, clr_err;
  logic [WIDTH-1:0] out_data;
  logic out_valid, busy, overrun, frame_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  shift_word_deserializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_en    (din_en),
    .sof       (sof),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  // ---------------------------------------------------------------
  // Counters and compare helper
  // ---------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model: a frame is a list of received bits; a word is
  // complete once the list holds WIDTH bits. The output holds one word.
  // ---------------------------------------------------------------
  logic             bits[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ovr;
  logic             m_ferr;

  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = bits[i];
    return w;
  endfunction

  task automatic model_reset();
    bits.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic model_step();
    logic             done, ferr_ev, ovr_ev;
    logic [WIDTH-1:0] word;
    done = 1'b0; ferr_ev = 1'b0; ovr_ev = 1'b0; word = '0;
    if (din_en) begin
      if (sof) begin
        if (bits.size() > 0) ferr_ev = 1'b1;
        bits.delete();
        bits.push_back(din);
      end else if (bits.size() > 0) begin
        bits.push_back(din);
        if (bits.size() == WIDTH) begin
          word = pack_bits();
          done = 1'b1;
          bits.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1;
        m_data  = word;
        exp_q.push_back(word);
      end else begin
        ovr_ev = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    m_ovr  = ovr_ev  | (m_ovr  & ~clr_err);
    m_ferr = ferr_ev | (m_ferr & ~clr_err);
  endtask

  always @(posedge clk) begin
    if (!rst) model_step();
  end

  // ---------------------------------------------------------------
  // Monitor / scoreboard: mid-cycle, compare state flags with the
  // model and pop the expected word for every handshake about to occur.
  // ---------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, m_valid);
      check("busy",      busy,      bits.size() > 0);
      check("overrun",   overrun,   m_ovr);
      check("frame_err", frame_err, m_ferr);
      check("out_data",  out_data,  m_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_empty", 1, 0);
        end else begin
          check("accepted_word", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic s, input logic d);
    din_en = e; sof = s; din = d;
    tick();
    din_en = 1'b0; sof = 1'b0; din = 1'b0;
  endtask

  // Full frame, MSB first, no gaps.
  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) drive(1'b1, i == WIDTH - 1, w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_out_data",  out_data,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_overrun",   overrun,   0);
    check("rst_frame_err", frame_err, 0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------
  initial begin
    rst = 1'b1; din = 1'b0; din_en = 1'b0; sof = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    tick();
    do_reset();
    tick();

    // 1: 1010 held until accepted
    out_ready = 1'b0;
    send_word(4'b1010);
    check("t1_data",  out_data,  4'b1010);
    check("t1_valid", out_valid, 1);
    tick(); tick();
    check("t1_hold",  out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_accepted", out_valid, 0);

    // 2: 1101 with a two-cycle gap after bit 2
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_gap_busy", busy, 1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    check("t2_data", out_data, 4'b1101);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 3: aborted frame then 0110
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    send_word(4'b0110);
    check("t3_ferr", frame_err, 1);
    check("t3_data", out_data, 4'b0110);
    clr_err = 1'b1; out_ready = 1'b1; tick(); clr_err = 1'b0; out_ready = 1'b0;
    check("t3_ferr_clr", frame_err, 0);

    // 4: overrun with out_ready low
    send_word(4'b1010);
    send_word(4'b0101);
    check("t4_data",    out_data, 4'b1010);
    check("t4_overrun", overrun,  1);
    out_ready = 1'b1; tick();
    check("t4_drained", out_valid, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // 5: back-to-back with out_ready held high
    send_word(4'b1010);
    check("t5_first", out_data, 4'b1010);
    send_word(4'b0101);
    check("t5_second", out_data, 4'b0101);
    check("t5_no_ovr", overrun, 0);
    tick();
    out_ready = 1'b0;

    // 6: reset mid-frame, then 0011
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    do_reset();
    send_word(4'b0011);
    check("t6_data", out_data, 4'b0011);
    check("t6_ferr", frame_err, 0);
    out_ready = 1'b1; tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      din_en    = ($urandom_range(99, 0) < 75);
      sof       = ($urandom_range(99, 0) < 15);
      din       = $urandom_range(1, 0);
      out_ready = ($urandom_range(99, 0) < 55);
      clr_err   = ($urandom_range(99, 0) < 4);
      tick();
    end

    // Drain and confirm every loaded word was accepted
    din_en = 1'b0; sof = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
